// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS memory-port sequencer.
// The optional timeout path is compiled in with MEM_TIMEOUT_EN.
package mips_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned TMR_W      = 5;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StReq  = 2'd1;
  localparam state_t StDone = 2'd2;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Controller-side request signals and memory-side req/ack bus of mem_port_ctrl.
// master is the sequencer's view; slave is the controller/memory environment.
interface mem_port_ctrl_if
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              start;
  logic              memwrite;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              mreq;
  logic              mwe;
  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] mwdata;
  logic [DATA_W-1:0] mrdata;
  logic              mack;

  modport master (
    input  start, memwrite, adr, writedata, mrdata, mack,
    output readdata, busy, done, err, mreq, mwe, maddr, mwdata
  );

  modport slave (
    output start, memwrite, adr, writedata, mrdata, mack,
    input  readdata, busy, done, err, mreq, mwe, maddr, mwdata
  );

endinterface

// File: rtl/mem_wait_timer.sv
// REQ-state wait counter with expiry compare; instantiated only when MEM_TIMEOUT_EN is defined.
module mem_wait_timer
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires on the TIMEOUT-th ackless REQ cycle; gating with inc_i lets a same-cycle mack win.
  assign expired_o = inc_i && (cnt_q == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Multicycle memory-port sequencer: one req/ack access per start, registered read data.
// Define MEM_TIMEOUT_EN to abort REQ after TIMEOUT ackless cycles.
module mem_port_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  mem_port_ctrl_if.master bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-3:0] wadr_q, wadr_d;
  logic              mwe_q, mwe_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              accept;
  logic              expired;

`ifdef MEM_TIMEOUT_EN
  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (accept),
    .inc_i     ((state_q == StReq) && !bus.mack),
    .expired_o (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wadr_d  = wadr_q;
    mwe_d   = mwe_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (is_word_aligned(bus.adr[1:0])) begin
            accept  = 1'b1;
            wadr_d  = bus.adr[ADDR_W-1:2];
            mwe_d   = bus.memwrite;
            wdata_d = bus.writedata;
            state_d = StReq;
          end else begin
            // Misaligned: flag and complete without touching memory.
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StReq: begin
        if (bus.mack) begin
          if (!mwe_q) begin
            rdata_d = bus.mrdata;
          end
          state_d = StDone;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wadr_q  <= '0;
      mwe_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wadr_q  <= wadr_d;
      mwe_q   <= mwe_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Every output is a decode of registered state, so mack/mrdata never reach an output directly.
  assign bus.mreq     = (state_q == StReq);
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.err      = err_q;
  assign bus.readdata = rdata_q;
  assign bus.mwe      = mwe_q;
  assign bus.maddr    = {wadr_q, 2'b00};
  assign bus.mwdata   = wdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed self-checking bench for mem_port_ctrl; timeout cases run when MEM_TIMEOUT_EN is defined.
module tb_mem_port_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_port_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd);
    bus.start     = 1'b1;
    bus.memwrite  = we;
    bus.adr       = a;
    bus.writedata = wd;
    step();
    bus.start     = 1'b0;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.memwrite  = 1'b0;
    bus.adr       = '0;
    bus.writedata = '0;
    bus.mrdata    = '0;
    bus.mack      = 1'b0;
    repeat (3) step();
    check_eq("rst_mreq_held", bus.mreq, 0);
    reset = 1'b0;
    step();
    check_eq("rst_readdata", bus.readdata, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_err", bus.err, 0);
    check_eq("rst_mreq", bus.mreq, 0);
    check_eq("rst_mwe", bus.mwe, 0);
    check_eq("rst_maddr", bus.maddr, 0);
    check_eq("rst_mwdata", bus.mwdata, 0);

    // Load, three wait cycles, ack on the fourth REQ edge: done seen after the fifth edge.
    issue(1'b0, 32'h0000_0040, 32'h0);
    check_eq("ld_mreq", bus.mreq, 1);
    check_eq("ld_maddr", bus.maddr, 32'h40);
    check_eq("ld_mwe", bus.mwe, 0);
    check_eq("ld_busy", bus.busy, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("ld_wait_mreq", bus.mreq, 1);
      check_eq("ld_wait_done", bus.done, 0);
    end
    bus.mack   = 1'b1;
    bus.mrdata = 32'hDEAD_BEEF;
    step();
    bus.mack   = 1'b0;
    check_eq("ld_done", bus.done, 1);
    check_eq("ld_readdata", bus.readdata, 32'hDEAD_BEEF);
    check_eq("ld_mreq_off", bus.mreq, 0);
    check_eq("ld_err", bus.err, 0);
    step();
    check_eq("ld_done_1cyc", bus.done, 0);
    check_eq("ld_idle_busy", bus.busy, 0);

    // Store with immediate ack.
    issue(1'b1, 32'h0000_0084, 32'h1234_5678);
    bus.mack   = 1'b1;
    bus.mrdata = 32'h5555_AAAA;
    check_eq("st_mreq", bus.mreq, 1);
    check_eq("st_mwe", bus.mwe, 1);
    check_eq("st_mwdata", bus.mwdata, 32'h1234_5678);
    check_eq("st_maddr", bus.maddr, 32'h84);
    step();
    bus.mack   = 1'b0;
    check_eq("st_done", bus.done, 1);
    check_eq("st_readdata", bus.readdata, 32'hDEAD_BEEF);
    step();
    check_eq("st_done_1cyc", bus.done, 0);

    // Misaligned: err and done next cycle, no memory request.
    issue(1'b0, 32'h0000_0042, 32'h0);
    check_eq("mis_err", bus.err, 1);
    check_eq("mis_done", bus.done, 1);
    check_eq("mis_mreq", bus.mreq, 0);
    step();
    check_eq("mis_done_1cyc", bus.done, 0);
    check_eq("mis_mreq2", bus.mreq, 0);
    issue(1'b0, 32'h0000_0100, 32'h0);
    check_eq("mis_next_maddr", bus.maddr, 32'h100);
    check_eq("mis_next_mreq", bus.mreq, 1);
    bus.mack   = 1'b1;
    bus.mrdata = 32'hCAFE_F00D;
    step();
    bus.mack   = 1'b0;
    check_eq("mis_next_done", bus.done, 1);
    check_eq("mis_next_rdata", bus.readdata, 32'hCAFE_F00D);
    check_eq("mis_err_sticky", bus.err, 1);
    step();

    // start during REQ ignored; mack in IDLE ignored.
    issue(1'b0, 32'h0000_0200, 32'h0);
    bus.start = 1'b1;
    bus.adr   = 32'h0000_0300;
    step();
    bus.start = 1'b0;
    check_eq("ign_start_maddr", bus.maddr, 32'h200);
    check_eq("ign_start_mreq", bus.mreq, 1);
    bus.mack   = 1'b1;
    bus.mrdata = 32'h1111_2222;
    step();
    bus.mack   = 1'b0;
    check_eq("ign_done", bus.done, 1);
    check_eq("ign_readdata", bus.readdata, 32'h1111_2222);
    step();
    check_eq("ign_no_second", bus.busy, 0);
    bus.mack   = 1'b1;
    bus.mrdata = 32'h9999_9999;
    step();
    bus.mack   = 1'b0;
    check_eq("ign_mack_done", bus.done, 0);
    check_eq("ign_mack_busy", bus.busy, 0);
    check_eq("ign_mack_rdata", bus.readdata, 32'h1111_2222);

    // Asynchronous reset while in REQ, then a late ack.
    issue(1'b1, 32'h0000_0400, 32'hAAAA_0001);
    check_eq("ar_mreq_before", bus.mreq, 1);
    #1 reset = 1'b1;
    #1;
    check_eq("ar_mreq", bus.mreq, 0);
    check_eq("ar_busy", bus.busy, 0);
    check_eq("ar_maddr", bus.maddr, 0);
    check_eq("ar_mwdata", bus.mwdata, 0);
    check_eq("ar_err", bus.err, 0);
    step();
    reset      = 1'b0;
    bus.mack   = 1'b1;
    bus.mrdata = 32'h7777_7777;
    step();
    bus.mack   = 1'b0;
    check_eq("ar_late_done", bus.done, 0);
    check_eq("ar_late_rdata", bus.readdata, 0);

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 15 REQ cycles.
    issue(1'b0, 32'h0000_0500, 32'h0);
    for (int i = 0; i < 14; i++) step();
    check_eq("to_mreq_14", bus.mreq, 1);
    step();
    check_eq("to_mreq_drop", bus.mreq, 0);
    check_eq("to_done", bus.done, 1);
    check_eq("to_err", bus.err, 1);
    check_eq("to_rdata", bus.readdata, 0);
    step();
    check_eq("to_done_1cyc", bus.done, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    // Ack on the 15th REQ cycle beats expiry.
    issue(1'b0, 32'h0000_0504, 32'h0);
    for (int i = 0; i < 14; i++) step();
    bus.mack   = 1'b1;
    bus.mrdata = 32'h0000_ABCD;
    step();
    bus.mack   = 1'b0;
    check_eq("to_ack_done", bus.done, 1);
    check_eq("to_ack_err", bus.err, 0);
    check_eq("to_ack_rdata", bus.readdata, 32'h0000_ABCD);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
